rectify_frame_ctrl: RTL and testbench
=====================================

RECTIFY_FRAME_CTRL -- requirements
Module: rectify_frame_ctrl

Interface
REQ-001 The block SHALL have parameter IMG_WIDTH, default 640: pixels per line.
REQ-002 The block SHALL have parameter IMG_HEIGHT, default 480: lines per frame (FRAME_PIX = IMG_WIDTH*IMG_HEIGHT).
REQ-003 The block SHALL have parameter PREFILL, default 355: accepted video beats before the LUT stream starts; constraint 0 < PREFILL < FRAME_PIX.
REQ-004 The block SHALL have parameter WDOG, default 4096: maximum idle cycles without any beat before timeout.
REQ-005 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous active-low reset (asserted = 0).
- frame_req  in  1  request to process one frame.
- abort  in  1  synchronous abort.
- vtvalid, vtready, vtlast  in  1 each  video AXI-stream monitor taps.
- ltvalid, ltready, ltlast  in  1 each  LUT AXI-stream monitor taps.
- recvalid, reclast  in  1 each  interpolator output taps.
- sv_start  out  1  one-cycle video source start pulse.
- sl_start  out  1  one-cycle LUT source start pulse.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle completion pulse.
- err_code  out  3  0 none, 1 vtlast mismatch, 2 ltlast mismatch, 3 reclast mismatch, 4 timeout.
- out_cnt  out  clog2(FRAME_PIX+1)  rectified pixels emitted this frame.

Function
REQ-006 Beats: video = vtvalid&vtready; LUT = ltvalid&ltready; output = recvalid.
REQ-007 FSM states SHALL be IDLE, PREFILL, RUN, DONE and ERROR.
REQ-008 IDLE: frame_req=1 with abort=0 -> PREFILL; sv_start=1 in the following cycle only; all counters cleared; err_code cleared to 0.
REQ-009 PREFILL: count video beats; on the cycle the count reaches PREFILL -> RUN; sl_start=1 in the following cycle only.
REQ-010 RUN: keep counting video, LUT and output beats, saturating at FRAME_PIX.
REQ-011 vtlast on a video beat SHALL be legal only when that beat is number FRAME_PIX; a mismatch in either direction (early vtlast, or beat FRAME_PIX without vtlast) -> ERROR, code 1.
REQ-012 The same rule SHALL apply to ltlast (code 2) and to reclast on output beats (code 3).
REQ-013 A correct reclast on output beat FRAME_PIX -> DONE; frame_done=1 for exactly one cycle; then IDLE.
REQ-014 In PREFILL and RUN, WDOG consecutive cycles with no beat of any kind -> ERROR, code 4; any beat reloads the watchdog.
REQ-015 Errors detected in the same cycle SHALL report the lowest nonzero code.
REQ-016 ERROR: err_code held, busy=0; frame_req restarts as in REQ-008.
REQ-017 busy=1 in PREFILL, RUN and DONE only.
REQ-018 frame_req while busy SHALL be ignored.
REQ-019 abort=1 in any state -> IDLE next cycle; counters cleared; err_code cleared; no frame_done, sv_start or sl_start pulse; abort wins over a simultaneous frame_req.
REQ-020 out_cnt SHALL update in the cycle after each output beat and hold its final value in IDLE until the next frame_req.
REQ-021 All outputs SHALL be registered.

Reset
REQ-022 rst=0 SHALL immediately, without a clock edge, force state IDLE, all counters 0, and sv_start, sl_start, busy, frame_done, err_code and out_cnt to 0.
REQ-023 Reset mid-frame SHALL abandon the frame silently; operation resumes on the first frame_req after rst returns to 1.

Structure
REQ-024 Package rectify_pkg SHALL hold the FSM state enum, the err_code constants and the FRAME_PIX width function.
REQ-025 The per-stream beat counter with last-check SHALL be sub-module frame_beat_cnt, instantiated three times (video, LUT, output).

Verification (IMG_WIDTH=8, IMG_HEIGHT=4, PREFILL=5, WDOG=16)
REQ-026 Nominal frame: frame_req -> sv_start one cycle later; sl_start one cycle after the 5th video beat; correct lasts on 32 beats per stream -> frame_done one pulse, out_cnt=32, busy falls.
REQ-027 vtlast on video beat 20 -> err_code=1, busy=0, no frame_done.
REQ-028 All streams stalled for 16 cycles in RUN -> err_code=4 on the 16th idle cycle.
REQ-029 abort at output beat 10 -> IDLE, out_cnt=0, no frame_done; the next frame_req completes normally.
REQ-030 frame_req during RUN is ignored; frame_req with abort in IDLE stays IDLE with no sv_start.
REQ-031 rst=0 between clock edges mid-RUN -> every output is 0 before the next edge.

Source files
------------

// File: rtl/rectify_pkg.sv
// Shared types and constants for the rectification frame controller.
package rectify_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PREFILL = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERROR   = 3'd4
  } state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_VLAST   = 3'd1;
  localparam logic [2:0] ERR_LLAST   = 3'd2;
  localparam logic [2:0] ERR_RLAST   = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/frame_beat_cnt.sv
// Per-stream beat counter, saturating at MAX, flagging a last marker on the wrong beat.
module frame_beat_cnt #(
  parameter int MAX = 32,
  parameter int CW  = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          beat,
  input  logic          last,
  output logic [CW-1:0] cnt,
  output logic          mismatch
);

  logic hit;
  logic at_last;

  assign hit      = en & beat;
  // The beat being accepted now is number cnt+1; only number MAX may carry last.
  assign at_last  = (cnt == CW'(MAX - 1));
  assign mismatch = hit & (last != at_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (hit && (cnt != CW'(MAX))) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/rectify_frame_ctrl.sv
// Frame sequencer for the rectifier: starts the video and LUT sources, checks
// framing on all three streams, runs a stall watchdog and reports completion.
module rectify_frame_ctrl
  import rectify_pkg::*;
#(
  parameter int  IMG_WIDTH  = 640,
  parameter int  IMG_HEIGHT = 480,
  parameter int  PREFILL    = 355,
  parameter int  WDOG       = 4096,
  localparam int FRAME_PIX  = IMG_WIDTH * IMG_HEIGHT,
  localparam int CW         = cnt_width(FRAME_PIX)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_req,
  input  logic          abort,
  input  logic          vtvalid,
  input  logic          vtready,
  input  logic          vtlast,
  input  logic          ltvalid,
  input  logic          ltready,
  input  logic          ltlast,
  input  logic          recvalid,
  input  logic          reclast,
  output logic          sv_start,
  output logic          sl_start,
  output logic          busy,
  output logic          frame_done,
  output logic [2:0]    err_code,
  output logic [CW-1:0] out_cnt,
  output state_t        fsm_state,
  output logic [CW-1:0] video_cnt,
  output logic [CW-1:0] lut_cnt
);

  localparam int WW = cnt_width(WDOG);

  state_t        state;
  logic [WW-1:0] wdog_cnt;

  logic       active, start, clr;
  logic       vbeat, lbeat, any_beat;
  logic       v_mis, l_mis, r_mis;
  logic       timeout, prefill_hit, rec_done;
  logic [2:0] err_now;

  assign vbeat    = vtvalid & vtready;
  assign lbeat    = ltvalid & ltready;
  assign any_beat = vbeat | lbeat | recvalid;

  assign active = (state == ST_PREFILL) || (state == ST_RUN);
  assign start  = ((state == ST_IDLE) || (state == ST_ERROR)) && frame_req && !abort;
  assign clr    = abort | start;

  frame_beat_cnt #(.MAX(FRAME_PIX), .CW(CW)) u_video_cnt (
    .clk(clk), .rst(rst), .clr(clr), .en(active),
    .beat(vbeat), .last(vtlast), .cnt(video_cnt), .mismatch(v_mis)
  );

  frame_beat_cnt #(.MAX(FRAME_PIX), .CW(CW)) u_lut_cnt (
    .clk(clk), .rst(rst), .clr(clr), .en(active),
    .beat(lbeat), .last(ltlast), .cnt(lut_cnt), .mismatch(l_mis)
  );

  frame_beat_cnt #(.MAX(FRAME_PIX), .CW(CW)) u_out_cnt (
    .clk(clk), .rst(rst), .clr(clr), .en(active),
    .beat(recvalid), .last(reclast), .cnt(out_cnt), .mismatch(r_mis)
  );

  assign prefill_hit = (state == ST_PREFILL) && vbeat && (video_cnt == CW'(PREFILL - 1));
  assign rec_done    = active && recvalid && reclast && !r_mis;
  assign timeout     = !any_beat && (wdog_cnt == WW'(WDOG - 1));

  // Simultaneous faults report the lowest code.
  always_comb begin
    err_now = ERR_NONE;
    if (v_mis)        err_now = ERR_VLAST;
    else if (l_mis)   err_now = ERR_LLAST;
    else if (r_mis)   err_now = ERR_RLAST;
    else if (timeout) err_now = ERR_TIMEOUT;
  end

  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      sv_start   <= 1'b0;
      sl_start   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err_code   <= ERR_NONE;
      wdog_cnt   <= '0;
    end else begin
      sv_start   <= 1'b0;
      sl_start   <= 1'b0;
      frame_done <= 1'b0;
      if (abort) begin
        state    <= ST_IDLE;
        busy     <= 1'b0;
        err_code <= ERR_NONE;
        wdog_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE, ST_ERROR: begin
            if (frame_req) begin
              state    <= ST_PREFILL;
              sv_start <= 1'b1;
              busy     <= 1'b1;
              err_code <= ERR_NONE;
              wdog_cnt <= '0;
            end
          end
          ST_PREFILL, ST_RUN: begin
            wdog_cnt <= any_beat ? '0 : wdog_cnt + WW'(1);
            if (err_now != ERR_NONE) begin
              state    <= ST_ERROR;
              err_code <= err_now;
              busy     <= 1'b0;
            end else if (rec_done) begin
              state      <= ST_DONE;
              frame_done <= 1'b1;
            end else if (prefill_hit) begin
              state    <= ST_RUN;
              sl_start <= 1'b1;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rectify_frame_ctrl.sv
// Directed bench for rectify_frame_ctrl: table of framing scenarios plus
// hand-written timeout, abort, busy-request and reset sequences.
`timescale 1ns/1ps
module tb_rectify_frame_ctrl;
  import rectify_pkg::*;

  localparam int FP = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_req = 1'b0, abort = 1'b0;
  logic       vtvalid = 1'b0, vtready = 1'b1, vtlast = 1'b0;
  logic       ltvalid = 1'b0, ltready = 1'b1, ltlast = 1'b0;
  logic       recvalid = 1'b0, reclast = 1'b0;
  logic       sv_start, sl_start, busy, frame_done;
  logic [2:0] err_code;
  logic [5:0] out_cnt, video_cnt, lut_cnt;
  state_t     fsm_state;

  rectify_frame_ctrl #(
    .IMG_WIDTH(8), .IMG_HEIGHT(4), .PREFILL(5), .WDOG(16)
  ) dut (
    .clk(clk), .rst(rst), .frame_req(frame_req), .abort(abort),
    .vtvalid(vtvalid), .vtready(vtready), .vtlast(vtlast),
    .ltvalid(ltvalid), .ltready(ltready), .ltlast(ltlast),
    .recvalid(recvalid), .reclast(reclast),
    .sv_start(sv_start), .sl_start(sl_start), .busy(busy),
    .frame_done(frame_done), .err_code(err_code), .out_cnt(out_cnt),
    .fsm_state(fsm_state), .video_cnt(video_cnt), .lut_cnt(lut_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [5:0] exp_q[$];

  typedef struct {
    int vlast_at;  // video beat carrying vtlast (0: never)
    int llast_at;
    int rlast_at;
    int abort_rs;  // abort once this many output beats were seen (-1: never)
    int exp_err;
    int exp_done;
    int exp_out;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    frame_req = 1'b0; abort = 1'b0;
    vtvalid = 1'b0; vtready = 1'b1; vtlast = 1'b0;
    ltvalid = 1'b0; ltready = 1'b1; ltlast = 1'b0;
    recvalid = 1'b0; reclast = 1'b0;
  endtask

  task automatic start_frame(input string tag);
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    check({tag, "_sv_start"}, sv_start, 1);
    check({tag, "_busy_start"}, busy, 1);
    check({tag, "_err_clear"}, err_code, 0);
    check({tag, "_out_clear"}, out_cnt, 0);
  endtask

  // Streams: video from sv_start, LUT from sl_start, output one beat behind LUT.
  task automatic run_vec(input int i);
    vec_t  v;
    int    vs, ls, rs, cyc, done_cnt, sl_cnt, sl_vs, done_out;
    bit    lut_on, aborted;
    string tag;
    v = vecs[i];
    tag = $sformatf("v%0d", i);
    exp_q.push_back(6'(v.exp_out));
    vs = 0; ls = 0; rs = 0; cyc = 0; done_cnt = 0; sl_cnt = 0; sl_vs = -1; done_out = -1;
    lut_on = 0; aborted = 0;
    start_frame(tag);
    while (busy && cyc < 200) begin
      if (v.abort_rs >= 0 && rs == v.abort_rs && !aborted) begin
        check({tag, "_pre_abort_out"}, out_cnt, rs);
        aborted = 1;
        abort = 1'b1;
        vtvalid = 1'b0; ltvalid = 1'b0; recvalid = 1'b0;
        vtlast = 1'b0; ltlast = 1'b0; reclast = 1'b0;
      end else begin
        vtvalid  = (vs < FP);
        vtlast   = vtvalid && (vs + 1 == v.vlast_at);
        ltvalid  = lut_on && (ls < FP);
        ltlast   = ltvalid && (ls + 1 == v.llast_at);
        recvalid = (rs < ls);
        reclast  = recvalid && (rs + 1 == v.rlast_at);
      end
      tick();
      abort = 1'b0;
      if (vtvalid && vtready) vs++;
      if (ltvalid && ltready) ls++;
      if (recvalid) rs++;
      if (sl_start) begin sl_cnt++; sl_vs = vs; lut_on = 1; end
      if (frame_done) begin done_cnt++; done_out = out_cnt; end
      cyc++;
    end
    idle_inputs();
    check({tag, "_bounded"}, int'(cyc < 200), 1);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_err_code"}, err_code, v.exp_err);
    check({tag, "_done_pulses"}, done_cnt, v.exp_done);
    check({tag, "_out_cnt"}, out_cnt, v.exp_out);
    check({tag, "_sl_pulses"}, sl_cnt, 1);
    check({tag, "_sl_after_5th"}, sl_vs, 5);
    if (v.exp_done != 0) check({tag, "_out_at_done"}, done_out, FP);
    repeat (3) tick();
    check({tag, "_out_hold"}, out_cnt, exp_q.pop_front());
    check({tag, "_err_hold"}, err_code, v.exp_err);
    check({tag, "_state"}, fsm_state, (v.exp_err != 0) ? ST_ERROR : ST_IDLE);
  endtask

  initial begin
    int sv_cnt, sl_cnt;
    vecs[0] = '{32, 32, 32, -1, 0, 1, 32};  // nominal
    vecs[1] = '{20, 32, 32, -1, 1, 0, 14};  // early vtlast
    vecs[2] = '{ 0, 32, 32, -1, 1, 0, 26};  // missing vtlast
    vecs[3] = '{32, 10, 32, -1, 2, 0,  9};  // early ltlast
    vecs[4] = '{32,  0, 32, -1, 2, 0, 31};  // missing ltlast
    vecs[5] = '{32, 32,  5, -1, 3, 0,  5};  // early reclast
    vecs[6] = '{32, 32,  0, -1, 3, 0, 32};  // missing reclast
    vecs[7] = '{20, 15, 32, -1, 1, 0, 14};  // video and LUT errors together
    vecs[8] = '{32, 32, 32, 10, 0, 0,  0};  // abort at output beat 10
    vecs[9] = '{32, 32, 32, -1, 0, 1, 32};  // nominal after abort

    idle_inputs();
    rst = 1'b0;
    #3;
    check("rst_busy", busy, 0);
    check("rst_sv_start", sv_start, 0);
    check("rst_err", err_code, 0);
    check("rst_out", out_cnt, 0);
    check("rst_state", fsm_state, ST_IDLE);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("idle_busy", busy, 0);

    for (int i = 0; i < 10; i++) run_vec(i);

    // Watchdog: stall all streams (video valid without ready) once in RUN.
    start_frame("to");
    vtvalid = 1'b1; vtready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("to_sl_start", sl_start, 1);
    vtready = 1'b0;
    for (int k = 0; k < 15; k++) tick();
    check("to_err_before", err_code, 0);
    check("to_busy_before", busy, 1);
    tick();
    check("to_err", err_code, ERR_TIMEOUT);
    check("to_busy", busy, 0);
    check("to_no_done", frame_done, 0);
    idle_inputs();

    // frame_req held while busy must not restart the frame.
    start_frame("rq");
    sv_cnt = 0; sl_cnt = 0;
    frame_req = 1'b1; vtvalid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (sv_start) sv_cnt++;
      if (sl_start) sl_cnt++;
    end
    check("rq_sv_pulses", sv_cnt, 0);
    check("rq_sl_pulses", sl_cnt, 1);
    check("rq_busy", busy, 1);
    idle_inputs();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("rq_abort_busy", busy, 0);
    check("rq_abort_state", fsm_state, ST_IDLE);

    // abort wins over frame_req in IDLE.
    frame_req = 1'b1; abort = 1'b1;
    tick();
    check("ab_sv_start", sv_start, 0);
    check("ab_busy", busy, 0);
    idle_inputs();
    tick();
    check("ab_sv_start2", sv_start, 0);
    check("ab_state", fsm_state, ST_IDLE);

    // Asynchronous reset mid-RUN, then a clean frame.
    start_frame("mr");
    vtvalid = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    ltvalid = 1'b1;
    tick();
    recvalid = 1'b1;
    repeat (2) tick();
    check("mr_out_before", out_cnt, 2);
    check("mr_busy_before", busy, 1);
    idle_inputs();
    #2;
    rst = 1'b0;
    #1;
    check("mr_busy", busy, 0);
    check("mr_sv", sv_start, 0);
    check("mr_sl", sl_start, 0);
    check("mr_done", frame_done, 0);
    check("mr_err", err_code, 0);
    check("mr_out", out_cnt, 0);
    check("mr_state", fsm_state, ST_IDLE);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("mr_busy_after", busy, 0);
    run_vec(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL sim_timeout: bench did not finish, got running, expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
